gshare_branch_predictor: RTL and testbench
==========================================

Name: gshare_branch_predictor

Overview:
Parametrised successor to the per-address branch history table. Combines a global history register (GHR) with a pattern history table (PHT) of saturating counters, indexed gshare-style (PC bits XOR history). Sits in fetch: it answers one prediction request per cycle and accepts one resolved-branch update per cycle from execute. It also supports speculative history with recovery on mispredict.

Parameters:
PHT_DEPTH, 128, number of PHT counters; power of two, >= 4; INDEX_BITS = clog2(PHT_DEPTH).
ADDR_WIDTH, 32, branch address width; >= INDEX_BITS+2.
HISTORY_BITS, 7, GHR length; 1 <= HISTORY_BITS <= INDEX_BITS.
COUNTER_WIDTH, 2, saturating counter width; >= 1.

Ports:
clk  in  1  clock, rising edge.
async_rst_n  in  1  asynchronous active-low reset.
clk_en  in  1  global enable; low freezes all state and outputs.
pred_req  in  1  prediction request this cycle.
pred_address  in  ADDR_WIDTH  branch PC to predict.
pred_resp_valid  out  1  response valid; 1-cycle latency after accepted request.
pred_taken  out  1  predicted direction (counter MSB).
pred_index  out  INDEX_BITS  PHT index used; requester returns it on update.
pred_ghr  out  HISTORY_BITS  GHR value before this prediction's shift; recovery snapshot.
upd_valid  in  1  resolved-branch update this cycle.
upd_index  in  INDEX_BITS  PHT entry to train.
upd_taken  in  1  actual outcome.
upd_mispredict  in  1  prediction was wrong; triggers GHR recovery.
upd_ghr  in  HISTORY_BITS  pred_ghr snapshot of the resolving branch.

Behaviour:
- Reset (async, while async_rst_n=0): every PHT counter = 2^(COUNTER_WIDTH-1)-1 (weakly not-taken; 01 for width 2, 0 for width 1). GHR=0. pred_resp_valid=0, pred_taken=0, pred_index=0, pred_ghr=0. Release is synchronous to clk by upstream.
- clk_en=0: no state changes; outputs hold; inputs ignored.
- Index: idx = pred_address[INDEX_BITS+1:2] XOR {zero-extend GHR to INDEX_BITS}. Address bits [1:0] are ignored.
- Prediction accepted when pred_req=1, clk_en=1 and not (upd_valid & upd_mispredict).
  - Next cycle: pred_resp_valid=1, pred_index=idx, pred_ghr=GHR (pre-shift), pred_taken=MSB of the counter value.
  - GHR <= {GHR[H-2:0], pred_taken_value}; for H=1, GHR <= pred_taken_value.
- No accepted request in a cycle: pred_resp_valid=0 next cycle; pred_taken, pred_index and pred_ghr hold their last values.
- Update (upd_valid=1, clk_en=1): counter[upd_index] +1 if upd_taken, else -1. Saturates at 0 and 2^COUNTER_WIDTH-1 with no wrap.
- Mispredict (upd_valid & upd_mispredict): GHR <= {upd_ghr[H-2:0], upd_taken}. This takes priority over any same-cycle prediction shift. A same-cycle pred_req is dropped (pred_resp_valid=0 next cycle) and the requester must reissue.
- upd_mispredict is ignored when upd_valid=0.
- Same-cycle update and prediction to the same index: the prediction uses the post-update counter value (write-to-read bypass).
- Non-mispredict updates never modify the GHR.
- Single write port; PHT is flop-based to allow async reset.

Test Plan:
- Reset then pred_req, pred_address=0x100 -> next cycle pred_resp_valid=1, pred_index=0x40, pred_taken=0, pred_ghr=0x00; GHR stays 0x00.
- From reset: two updates upd_index=0x40 taken=1 (no mispredict), then predict 0x100 -> pred_taken=1, pred_index=0x40; next predict 0x100 -> pred_index=0x41, pred_ghr=0x01.
- Saturation at idx 0x10: six taken updates -> counter=3. Four not-taken updates -> 0. Two more not-taken -> stays 0, and a prediction there gives pred_taken=0.
- Mispredict: upd_valid=1, upd_mispredict=1, upd_ghr=0x15, upd_taken=1, with pred_req=1 the same cycle -> GHR=0x2B, pred_resp_valid=0 next cycle. The next predict of 0x000 gives pred_index=0x2B.
- Bypass: counter[0x40]=1, same cycle upd_index=0x40 taken=1 and predict 0x100 with GHR=0 -> pred_taken=1.
- clk_en=0 for 3 cycles with requests and updates -> outputs, GHR and counters unchanged. Assert async_rst_n=0 mid-stream without a clock edge -> outputs go to 0 immediately and counters return to 01.

Source files
------------

// File: rtl/gshare_branch_predictor_if.sv
// Fetch/execute side bundle of the gshare predictor: prediction request and
// response, plus the resolved-branch update channel.
//
// Handshake: there is no ready signal. A request (pred_req=1) is taken in
// any enabled cycle, except a cycle that also carries a mispredict update
// (upd_valid & upd_mispredict). Such a request is dropped and the requester
// must reissue it. pred_resp_valid pulses for one cycle, one cycle after an
// accepted request. An update (upd_valid=1) is always taken in an enabled
// cycle.
interface gshare_branch_predictor_if #(
   parameter int ADDR_WIDTH   = 32,
   parameter int INDEX_BITS   = 7,
   parameter int HISTORY_BITS = 7
);
   logic                    pred_req;
   logic [ADDR_WIDTH-1:0]   pred_address;
   logic                    pred_resp_valid;
   logic                    pred_taken;
   logic [INDEX_BITS-1:0]   pred_index;
   logic [HISTORY_BITS-1:0] pred_ghr;
   logic                    upd_valid;
   logic [INDEX_BITS-1:0]   upd_index;
   logic                    upd_taken;
   logic                    upd_mispredict;
   logic [HISTORY_BITS-1:0] upd_ghr;

   // Requester / execute side
   modport master (
      output pred_req, pred_address,
      output upd_valid, upd_index, upd_taken, upd_mispredict, upd_ghr,
      input  pred_resp_valid, pred_taken, pred_index, pred_ghr
   );

   // Predictor side
   modport slave (
      input  pred_req, pred_address,
      input  upd_valid, upd_index, upd_taken, upd_mispredict, upd_ghr,
      output pred_resp_valid, pred_taken, pred_index, pred_ghr
   );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Gshare branch predictor. The global history register is XORed with PC
// bits to index a table of saturating counters. The history is updated
// speculatively on every prediction and restored from the resolving
// branch's snapshot on a mispredict.
module gshare_branch_predictor #(
   parameter int PHT_DEPTH     = 128,
   parameter int ADDR_WIDTH    = 32,
   parameter int HISTORY_BITS  = 7,
   parameter int COUNTER_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  async_rst_n,
   input  logic                  clk_en,
   gshare_branch_predictor_if.slave bus
);
   localparam int INDEX_BITS = $clog2(PHT_DEPTH);
   localparam logic [COUNTER_WIDTH-1:0] CNT_INIT = COUNTER_WIDTH'((2 ** (COUNTER_WIDTH - 1)) - 1);
   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = {COUNTER_WIDTH{1'b1}};
   localparam logic [COUNTER_WIDTH-1:0] CNT_MIN  = '0;
   // Address bits that do not take part in indexing
   localparam logic [ADDR_WIDTH-1:0] ADDR_IDLE_MASK =
      {ADDR_WIDTH{1'b1}} ^ (ADDR_WIDTH'(PHT_DEPTH - 1) << 2);

   logic [COUNTER_WIDTH-1:0] r_pht [PHT_DEPTH];
   logic [HISTORY_BITS-1:0]  r_ghr;
   logic                     r_resp_valid;
   logic                     r_taken;
   logic [INDEX_BITS-1:0]    r_index;
   logic [HISTORY_BITS-1:0]  r_ghr_snap;

   logic [INDEX_BITS-1:0]    w_pred_idx;
   logic [COUNTER_WIDTH-1:0] w_upd_cur;
   logic [COUNTER_WIDTH-1:0] w_upd_next;
   logic [COUNTER_WIDTH-1:0] w_pred_cnt;
   logic                     w_pred_taken;
   logic                     w_mispredict;
   logic                     w_accept;
   logic [HISTORY_BITS-1:0]  w_ghr_next;
   logic                     w_unused_addr;

   assign w_unused_addr = ^(bus.pred_address & ADDR_IDLE_MASK);

   assign w_pred_idx   = bus.pred_address[INDEX_BITS+1:2] ^ INDEX_BITS'(r_ghr);
   assign w_mispredict = bus.upd_valid & bus.upd_mispredict;
   assign w_accept     = bus.pred_req & ~w_mispredict;

   // Saturating increment/decrement of the counter being trained
   always_comb begin
      w_upd_cur  = r_pht[bus.upd_index];
      w_upd_next = w_upd_cur;
      if (bus.upd_taken) begin
         if (w_upd_cur != CNT_MAX) w_upd_next = w_upd_cur + COUNTER_WIDTH'(1);
      end else begin
         if (w_upd_cur != CNT_MIN) w_upd_next = w_upd_cur - COUNTER_WIDTH'(1);
      end
   end

   // Prediction read, with the same-cycle update bypassed in when indices match
   always_comb begin
      w_pred_cnt = r_pht[w_pred_idx];
      if (bus.upd_valid && (bus.upd_index == w_pred_idx)) w_pred_cnt = w_upd_next;
      w_pred_taken = w_pred_cnt[COUNTER_WIDTH-1];
   end

   // Next history: recovery beats speculative shift; otherwise hold
   always_comb begin
      w_ghr_next = r_ghr;
      if (w_mispredict) begin
         w_ghr_next = HISTORY_BITS'({bus.upd_ghr, bus.upd_taken});
      end else if (w_accept) begin
         w_ghr_next = HISTORY_BITS'({r_ghr, w_pred_taken});
      end
   end

   // Pattern history table: single write port, flop based for async reset
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         for (int i = 0; i < PHT_DEPTH; i++) r_pht[i] <= CNT_INIT;
      end else if (clk_en && bus.upd_valid) begin
         r_pht[bus.upd_index] <= w_upd_next;
      end
   end

   // History register and registered response; fields hold when no request is taken
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         r_ghr        <= '0;
         r_resp_valid <= 1'b0;
         r_taken      <= 1'b0;
         r_index      <= '0;
         r_ghr_snap   <= '0;
      end else if (clk_en) begin
         r_ghr        <= w_ghr_next;
         r_resp_valid <= w_accept;
         if (w_accept) begin
            r_taken    <= w_pred_taken;
            r_index    <= w_pred_idx;
            r_ghr_snap <= r_ghr;
         end
      end
   end

   assign bus.pred_resp_valid = r_resp_valid;
   assign bus.pred_taken      = r_taken;
   assign bus.pred_index      = r_index;
   assign bus.pred_ghr        = r_ghr_snap;
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Testbench for gshare_branch_predictor: directed scenarios plus a
// randomized run, all checked against a behavioural table/history model.
module tb_gshare_branch_predictor;
   localparam int PHT_DEPTH     = 128;
   localparam int ADDR_WIDTH    = 32;
   localparam int HISTORY_BITS  = 7;
   localparam int COUNTER_WIDTH = 2;
   localparam int INDEX_BITS    = 7;
   localparam int RW            = 2 + INDEX_BITS + HISTORY_BITS;
   localparam int CNT_HALF      = 2 ** (COUNTER_WIDTH - 1);
   localparam int CNT_MAX       = 2 ** COUNTER_WIDTH - 1;
   localparam int HIST_MOD      = 2 ** HISTORY_BITS;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic async_rst_n = 1'b0;
   logic clk_en = 1'b0;
   always #5 clk = ~clk;

   gshare_branch_predictor_if #(
      .ADDR_WIDTH(ADDR_WIDTH), .INDEX_BITS(INDEX_BITS), .HISTORY_BITS(HISTORY_BITS)
   ) bus ();

   gshare_branch_predictor #(
      .PHT_DEPTH(PHT_DEPTH), .ADDR_WIDTH(ADDR_WIDTH),
      .HISTORY_BITS(HISTORY_BITS), .COUNTER_WIDTH(COUNTER_WIDTH)
   ) dut (
      .clk(clk),
      .async_rst_n(async_rst_n),
      .clk_en(clk_en),
      .bus(bus.slave)
   );

   int errors = 0;
   int checks = 0;

   // ---------------- reference model ----------------
   int m_pht[PHT_DEPTH];
   int m_ghr;
   int e_valid, e_taken, e_idx, e_ghr;
   logic [RW-1:0] exp_q[$];

   task automatic model_reset();
      for (int i = 0; i < PHT_DEPTH; i++) m_pht[i] = CNT_HALF - 1;
      m_ghr = 0;
      e_valid = 0; e_taken = 0; e_idx = 0; e_ghr = 0;
      exp_q.delete();
   endtask

   // One clock of the predictor, computed from the current inputs
   task automatic model_clock();
      int idx, cnt;
      bit mis, tk;
      if (clk_en) begin
         idx = int'((bus.pred_address >> 2) % PHT_DEPTH) ^ m_ghr;
         if (bus.upd_valid) begin
            cnt = m_pht[bus.upd_index] + (bus.upd_taken ? 1 : -1);
            if (cnt < 0) cnt = 0;
            if (cnt > CNT_MAX) cnt = CNT_MAX;
            m_pht[bus.upd_index] = cnt;
         end
         mis = bus.upd_valid && bus.upd_mispredict;
         if (bus.pred_req && !mis) begin
            tk = (m_pht[idx] >= CNT_HALF);
            e_valid = 1; e_taken = tk; e_idx = idx; e_ghr = m_ghr;
            m_ghr = (m_ghr * 2 + int'(tk)) % HIST_MOD;
         end else begin
            e_valid = 0;
         end
         if (mis) m_ghr = (int'(bus.upd_ghr) * 2 + int'(bus.upd_taken)) % HIST_MOD;
      end
      exp_q.push_back({1'(e_valid), 1'(e_taken), INDEX_BITS'(e_idx), HISTORY_BITS'(e_ghr)});
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_in(input bit req, input int addr, input bit uv, input int ui,
                         input bit ut, input bit um, input int ug);
      bus.pred_req       = req;
      bus.pred_address   = ADDR_WIDTH'(addr);
      bus.upd_valid      = uv;
      bus.upd_index      = INDEX_BITS'(ui);
      bus.upd_taken      = ut;
      bus.upd_mispredict = um;
      bus.upd_ghr        = HISTORY_BITS'(ug);
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Advance model and DUT by one clock; outputs are sampled 1ns after the edge
   task automatic step();
      model_clock();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      #1;
      async_rst_n = 1'b0;
      idle();
      @(posedge clk);
      @(negedge clk);
      async_rst_n = 1'b1;
      clk_en = 1'b1;
      model_reset();
   endtask

   function automatic logic [RW-1:0] dut_out();
      return {bus.pred_resp_valid, bus.pred_taken, bus.pred_index, bus.pred_ghr};
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [RW-1:0] got;
      idle();
      #1;
      got = dut_out();
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got=%h exp=%h", got, {RW{1'b0}});
      end
      apply_reset();
   endtask

   task automatic test_predict_basic();
      logic [RW-1:0] got, exp;
      apply_reset();
      set_in(1, 'h100, 0, 0, 0, 0, 0);
      step();
      got = dut_out(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL basic_model: got=%h exp=%h", got, exp); end
      checks++;
      if (got !== {1'b1, 1'b0, 7'h40, 7'h00}) begin
         errors++; $display("FAIL basic_first_pred: got=%h exp=%h", got, {1'b1, 1'b0, 7'h40, 7'h00});
      end
      // GHR still zero: address 0 must map to index 0 with snapshot 0
      set_in(1, 'h000, 0, 0, 0, 0, 0);
      step();
      got = dut_out(); exp = exp_q.pop_front();
      checks++;
      if (got !== {1'b1, 1'b0, 7'h00, 7'h00}) begin
         errors++; $display("FAIL basic_ghr_zero: got=%h exp=%h", got, exp);
      end
      // No request: valid drops, other fields hold
      idle();
      step();
      got = dut_out(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp || got[RW-1] !== 1'b0) begin
         errors++; $display("FAIL basic_idle_hold: got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_train();
      logic [RW-1:0] got, exp;
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         set_in(0, 0, 1, 'h40, 1, 0, 0);
         step();
         got = dut_out(); exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin errors++; $display("FAIL train_upd%0d: got=%h exp=%h", i, got, exp); end
      end
      set_in(1, 'h100, 0, 0, 0, 0, 0);
      step();
      got = dut_out(); exp = exp_q.pop_front();
      checks++;
      if (got !== {1'b1, 1'b1, 7'h40, 7'h00} || got !== exp) begin
         errors++; $display("FAIL train_pred_taken: got=%h exp=%h", got, exp);
      end
      set_in(1, 'h100, 0, 0, 0, 0, 0);
      step();
      got = dut_out(); exp = exp_q.pop_front();
      checks++;
      if (got[INDEX_BITS+HISTORY_BITS-1:0] !== {7'h41, 7'h01} || got !== exp) begin
         errors++; $display("FAIL train_ghr_shift: got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_saturation();
      logic [RW-1:0] got, exp;
      int seq_t[3] = '{6, 4, 2};
      bit seq_d[3] = '{1'b1, 1'b0, 1'b0};
      bit want[3]  = '{1'b1, 1'b0, 1'b0};
      apply_reset();
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < seq_t[s]; i++) begin
            set_in(0, 0, 1, 'h10, seq_d[s], 0, 0);
            step();
            void'(exp_q.pop_front());
         end
         // Probe entry 0x10 through the current history
         set_in(1, (('h10 ^ m_ghr) << 2), 0, 0, 0, 0, 0);
         step();
         got = dut_out(); exp = exp_q.pop_front();
         checks++;
         if (got !== exp || got[RW-2] !== want[s] || got[INDEX_BITS+HISTORY_BITS-1:HISTORY_BITS] !== 7'h10) begin
            errors++; $display("FAIL sat_phase%0d: got=%h exp=%h", s, got, exp);
         end
      end
   endtask

   task automatic test_mispredict();
      logic [RW-1:0] got, exp;
      apply_reset();
      set_in(1, 'h100, 1, 'h05, 1, 1, 'h15);
      step();
      got = dut_out(); exp = exp_q.pop_front();
      checks++;
      if (got !== '0 || got !== exp) begin
         errors++; $display("FAIL mis_drop_req: got=%h exp=%h", got, exp);
      end
      set_in(1, 'h000, 0, 0, 0, 0, 0);
      step();
      got = dut_out(); exp = exp_q.pop_front();
      checks++;
      if (got[INDEX_BITS+HISTORY_BITS-1:0] !== {7'h2B, 7'h2B} || got !== exp) begin
         errors++; $display("FAIL mis_recovered_ghr: got=%h exp=%h", got, exp);
      end
      // upd_mispredict without upd_valid is ignored
      set_in(1, 'h000, 0, 0, 1, 1, 'h7F);
      step();
      got = dut_out(); exp = exp_q.pop_front();
      checks++;
      if (got[RW-1] !== 1'b1 || got !== exp) begin
         errors++; $display("FAIL mis_ignored_no_valid: got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_bypass();
      logic [RW-1:0] got, exp;
      apply_reset();
      set_in(1, 'h100, 1, 'h40, 1, 0, 0);
      step();
      got = dut_out(); exp = exp_q.pop_front();
      checks++;
      if (got !== {1'b1, 1'b1, 7'h40, 7'h00} || got !== exp) begin
         errors++; $display("FAIL bypass_taken: got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_clk_en_freeze();
      logic [RW-1:0] got, exp;
      apply_reset();
      set_in(0, 0, 1, 'h22, 1, 0, 0); step(); void'(exp_q.pop_front());
      set_in(1, 'h088, 0, 0, 0, 0, 0); step(); void'(exp_q.pop_front());
      clk_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(1, $urandom, 1, $urandom_range(0, 127), 1, i == 1, $urandom_range(0, 127));
         step();
         got = dut_out(); exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin errors++; $display("FAIL freeze_hold%0d: got=%h exp=%h", i, got, exp); end
      end
      clk_en = 1'b1;
      // History and counters must be as before the freeze
      for (int i = 0; i < 4; i++) begin
         set_in(1, ((i * 'h11) << 2), 0, 0, 0, 0, 0);
         step();
         got = dut_out(); exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin errors++; $display("FAIL freeze_after%0d: got=%h exp=%h", i, got, exp); end
      end
   endtask

   task automatic test_back_to_back_random();
      logic [RW-1:0] got, exp;
      int addr;
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         clk_en = ($urandom_range(0, 9) != 0);
         addr = ($urandom_range(0, 1) == 1) ? ($urandom_range(0, 15) << 2) : int'($urandom);
         set_in($urandom_range(0, 3) != 0, addr, $urandom_range(0, 1),
                ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, 127),
                $urandom_range(0, 1), $urandom_range(0, 4) == 0, $urandom_range(0, 127));
         step();
         got = dut_out(); exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin errors++; $display("FAIL random_cycle%0d: got=%h exp=%h", c, got, exp); end
      end
      clk_en = 1'b1;
   endtask

   task automatic test_async_reset();
      logic [RW-1:0] got, exp;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 1, 'h40, 1, 0, 0); step(); void'(exp_q.pop_front());
      end
      set_in(1, 'h104, 0, 0, 0, 0, 0);
      step();
      got = dut_out(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL areset_pre: got=%h exp=%h", got, exp); end
      // Assert reset between edges and check outputs clear at once
      #2;
      async_rst_n = 1'b0;
      #1;
      got = dut_out();
      checks++;
      if (got !== '0) begin errors++; $display("FAIL areset_immediate: got=%h exp=%h", got, {RW{1'b0}}); end
      idle();
      @(posedge clk);
      @(negedge clk);
      async_rst_n = 1'b1;
      model_reset();
      // Entry 0x40 was trained to strongly taken; must read weakly not-taken again
      set_in(1, 'h100, 0, 0, 0, 0, 0);
      step();
      got = dut_out(); exp = exp_q.pop_front();
      checks++;
      if (got !== {1'b1, 1'b0, 7'h40, 7'h00} || got !== exp) begin
         errors++; $display("FAIL areset_counter_init: got=%h exp=%h", got, exp);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_predict_basic();
      test_train();
      test_saturation();
      test_mispredict();
      test_bypass();
      test_clk_en_freeze();
      test_back_to_back_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
